// File: rtl/coreriscv_axi4_axi2tl_bridge_pkg.sv
// coreriscv_axi4_axi2tl_bridge_pkg: TileLink acquire/grant type codes, AXI response codes and bridge FSM states
package coreriscv_axi4_axi2tl_bridge_pkg;
  localparam logic [2:0] A_GET = 3'h0;
  localparam logic [2:0] A_PUT = 3'h2;
  localparam logic [3:0] G_GETDATABEAT = 4'h4;
  localparam logic [3:0] G_PUTACK = 4'h3;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  typedef enum logic [2:0] {IDLE, ACQ, WAIT_GNT, RESP_B, RESP_R} state_t;
endpackage

// File: rtl/coreriscv_axi4_axi2tl_bridge_if.sv
// coreriscv_axi4_axi2tl_bridge_if: AXI4 single-beat slave port plus TileLink acquire/grant master port
// Ports: AXI AW/W/B/AR/R channels and TL acquire/grant channels; slave modport = bridge, master modport = AXI master and TL manager
interface coreriscv_axi4_axi2tl_bridge_if #(parameter int ID_WIDTH = 4);
  logic io_axi_aw_valid, io_axi_aw_ready;
  logic [ID_WIDTH-1:0] io_axi_aw_id;
  logic [31:0] io_axi_aw_addr;
  logic io_axi_w_valid, io_axi_w_ready;
  logic [63:0] io_axi_w_data;
  logic [7:0] io_axi_w_strb;
  logic io_axi_b_valid, io_axi_b_ready;
  logic [ID_WIDTH-1:0] io_axi_b_id;
  logic [1:0] io_axi_b_resp;
  logic io_axi_ar_valid, io_axi_ar_ready;
  logic [ID_WIDTH-1:0] io_axi_ar_id;
  logic [31:0] io_axi_ar_addr;
  logic io_axi_r_valid, io_axi_r_ready;
  logic [ID_WIDTH-1:0] io_axi_r_id;
  logic [63:0] io_axi_r_data;
  logic [1:0] io_axi_r_resp;
  logic io_axi_r_last;
  logic io_tl_acquire_valid, io_tl_acquire_ready;
  logic [25:0] io_tl_acquire_bits_addr_block;
  logic [1:0] io_tl_acquire_bits_client_xact_id;
  logic [2:0] io_tl_acquire_bits_addr_beat;
  logic io_tl_acquire_bits_is_builtin_type;
  logic [2:0] io_tl_acquire_bits_a_type;
  logic [11:0] io_tl_acquire_bits_union;
  logic [63:0] io_tl_acquire_bits_data;
  logic io_tl_grant_valid, io_tl_grant_ready;
  logic [2:0] io_tl_grant_bits_addr_beat;
  logic [1:0] io_tl_grant_bits_client_xact_id;
  logic io_tl_grant_bits_manager_xact_id;
  logic io_tl_grant_bits_is_builtin_type;
  logic [3:0] io_tl_grant_bits_g_type;
  logic [63:0] io_tl_grant_bits_data;
  modport slave (
    input io_axi_aw_valid, io_axi_aw_id, io_axi_aw_addr, io_axi_w_valid, io_axi_w_data, io_axi_w_strb,
    input io_axi_b_ready, io_axi_ar_valid, io_axi_ar_id, io_axi_ar_addr, io_axi_r_ready,
    output io_axi_aw_ready, io_axi_w_ready, io_axi_b_valid, io_axi_b_id, io_axi_b_resp,
    output io_axi_ar_ready, io_axi_r_valid, io_axi_r_id, io_axi_r_data, io_axi_r_resp, io_axi_r_last,
    output io_tl_acquire_valid, io_tl_acquire_bits_addr_block, io_tl_acquire_bits_client_xact_id,
    output io_tl_acquire_bits_addr_beat, io_tl_acquire_bits_is_builtin_type, io_tl_acquire_bits_a_type,
    output io_tl_acquire_bits_union, io_tl_acquire_bits_data, io_tl_grant_ready,
    input io_tl_acquire_ready, io_tl_grant_valid, io_tl_grant_bits_addr_beat, io_tl_grant_bits_client_xact_id,
    input io_tl_grant_bits_manager_xact_id, io_tl_grant_bits_is_builtin_type, io_tl_grant_bits_g_type,
    input io_tl_grant_bits_data
  );
  modport master (
    output io_axi_aw_valid, io_axi_aw_id, io_axi_aw_addr, io_axi_w_valid, io_axi_w_data, io_axi_w_strb,
    output io_axi_b_ready, io_axi_ar_valid, io_axi_ar_id, io_axi_ar_addr, io_axi_r_ready,
    input io_axi_aw_ready, io_axi_w_ready, io_axi_b_valid, io_axi_b_id, io_axi_b_resp,
    input io_axi_ar_ready, io_axi_r_valid, io_axi_r_id, io_axi_r_data, io_axi_r_resp, io_axi_r_last,
    input io_tl_acquire_valid, io_tl_acquire_bits_addr_block, io_tl_acquire_bits_client_xact_id,
    input io_tl_acquire_bits_addr_beat, io_tl_acquire_bits_is_builtin_type, io_tl_acquire_bits_a_type,
    input io_tl_acquire_bits_union, io_tl_acquire_bits_data, io_tl_grant_ready,
    output io_tl_acquire_ready, io_tl_grant_valid, io_tl_grant_bits_addr_beat, io_tl_grant_bits_client_xact_id,
    output io_tl_grant_bits_manager_xact_id, io_tl_grant_bits_is_builtin_type, io_tl_grant_bits_g_type,
    output io_tl_grant_bits_data
  );
endinterface

// File: rtl/coreriscv_axi4_axi2tl_capture.sv
// coreriscv_axi4_axi2tl_capture: AW/W/AR holding registers with read/write alternating arbiter
// Ports: clk/reset, idle enables acceptance, raw AXI valids and payloads in, readies and held payloads out,
// clr_wr/clr_rd drop the held request on response handshake, start/start_wr report the chosen request
module coreriscv_axi4_axi2tl_capture #(parameter int ID_WIDTH = 4) (
  input  logic clk,
  input  logic reset,
  input  logic idle,
  input  logic aw_valid,
  input  logic [ID_WIDTH-1:0] aw_id_in,
  input  logic [31:0] aw_addr_in,
  input  logic w_valid,
  input  logic [63:0] w_data_in,
  input  logic [7:0] w_strb_in,
  input  logic ar_valid,
  input  logic [ID_WIDTH-1:0] ar_id_in,
  input  logic [31:0] ar_addr_in,
  input  logic clr_wr,
  input  logic clr_rd,
  output logic aw_ready,
  output logic w_ready,
  output logic ar_ready,
  output logic [ID_WIDTH-1:0] aw_id,
  output logic [31:0] aw_addr,
  output logic [63:0] w_data,
  output logic [7:0] w_strb,
  output logic [ID_WIDTH-1:0] ar_id,
  output logic [31:0] ar_addr,
  output logic start,
  output logic start_wr
);
  logic aw_cap, w_cap, ar_cap, last_rd, aw_fire, w_fire, ar_fire, wr_elig, rd_elig;
  assign aw_ready = idle && !aw_cap;
  assign w_ready = idle && !w_cap;
  assign ar_ready = idle && !ar_cap && !aw_cap && !w_cap;
  assign aw_fire = aw_valid && aw_ready;
  assign w_fire = w_valid && w_ready;
  assign ar_fire = ar_valid && ar_ready;
  // Same-cycle handshakes count as captured so the acquire follows one cycle after acceptance
  assign wr_elig = (aw_cap || aw_fire) && (w_cap || w_fire);
  assign rd_elig = ar_cap || ar_fire;
  assign start = idle && (wr_elig || rd_elig);
  assign start_wr = wr_elig && (!rd_elig || last_rd);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {aw_cap, w_cap, ar_cap, last_rd} <= '0;
      aw_id <= '0;
      aw_addr <= '0;
      w_data <= '0;
      w_strb <= '0;
      ar_id <= '0;
      ar_addr <= '0;
    end else begin
      aw_cap <= aw_fire || (aw_cap && !clr_wr);
      w_cap <= w_fire || (w_cap && !clr_wr);
      ar_cap <= ar_fire || (ar_cap && !clr_rd);
      if (aw_fire) {aw_id, aw_addr} <= {aw_id_in, aw_addr_in};
      if (w_fire) {w_data, w_strb} <= {w_data_in, w_strb_in};
      if (ar_fire) {ar_id, ar_addr} <= {ar_id_in, ar_addr_in};
      if (start) last_rd <= !start_wr;
    end
endmodule

// File: rtl/coreriscv_axi4_axi2tl_bridge.sv
// coreriscv_axi4_axi2tl_bridge: AXI4 single-beat slave to TileLink builtin Get/Put acquire master, one transaction outstanding
// Ports: clk, reset (async active-high), bus (coreriscv_axi4_axi2tl_bridge_if.slave: AXI AW/W/B/AR/R, TL acquire/grant)
// Option: CORERISCV_AXI4_TL_TIMEOUT_EN adds a TIMEOUT_CYCLES grant-wait limit answering DECERR and discarding the late grant
module coreriscv_axi4_axi2tl_bridge
  import coreriscv_axi4_axi2tl_bridge_pkg::*;
#(
  parameter int ID_WIDTH = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic reset,
  coreriscv_axi4_axi2tl_bridge_if.slave bus
);
  state_t state, state_nx;
  logic idle, start, start_wr, cur_wr, acq_fire, gnt_fire, gnt_take, gnt_ok, tmo, blocked, unused_grant;
  logic [1:0] xact_cnt, resp;
  logic [63:0] rdata, w_data;
  logic [31:0] aw_addr, ar_addr, addr;
  logic [7:0] w_strb;
  logic [ID_WIDTH-1:0] aw_id, ar_id;
  assign idle = state == IDLE && !reset;
  coreriscv_axi4_axi2tl_capture #(.ID_WIDTH(ID_WIDTH)) u_capture (
    .clk(clk), .reset(reset), .idle(idle),
    .aw_valid(bus.io_axi_aw_valid), .aw_id_in(bus.io_axi_aw_id), .aw_addr_in(bus.io_axi_aw_addr),
    .w_valid(bus.io_axi_w_valid), .w_data_in(bus.io_axi_w_data), .w_strb_in(bus.io_axi_w_strb),
    .ar_valid(bus.io_axi_ar_valid), .ar_id_in(bus.io_axi_ar_id), .ar_addr_in(bus.io_axi_ar_addr),
    .clr_wr(bus.io_axi_b_valid && bus.io_axi_b_ready), .clr_rd(bus.io_axi_r_valid && bus.io_axi_r_ready),
    .aw_ready(bus.io_axi_aw_ready), .w_ready(bus.io_axi_w_ready), .ar_ready(bus.io_axi_ar_ready),
    .aw_id(aw_id), .aw_addr(aw_addr), .w_data(w_data), .w_strb(w_strb), .ar_id(ar_id), .ar_addr(ar_addr),
    .start(start), .start_wr(start_wr)
  );
  assign addr = cur_wr ? aw_addr : ar_addr;
  assign bus.io_tl_acquire_valid = state == ACQ && !blocked;
  assign bus.io_tl_acquire_bits_addr_block = addr[31:6];
  assign bus.io_tl_acquire_bits_addr_beat = addr[5:3];
  assign bus.io_tl_acquire_bits_client_xact_id = xact_cnt;
  assign bus.io_tl_acquire_bits_is_builtin_type = 1'b1;
  assign bus.io_tl_acquire_bits_a_type = cur_wr ? A_PUT : A_GET;
  assign bus.io_tl_acquire_bits_union = cur_wr ? {3'h0, w_strb, 1'b0} : {addr[2:0], 3'h3, 5'h0, 1'b0};
  assign bus.io_tl_acquire_bits_data = cur_wr ? w_data : 64'h0;
  assign bus.io_axi_b_valid = state == RESP_B;
  assign bus.io_axi_b_id = aw_id;
  assign bus.io_axi_b_resp = resp;
  assign bus.io_axi_r_valid = state == RESP_R;
  assign bus.io_axi_r_id = ar_id;
  assign bus.io_axi_r_data = rdata;
  assign bus.io_axi_r_resp = resp;
  assign bus.io_axi_r_last = 1'b1;
  assign acq_fire = bus.io_tl_acquire_valid && bus.io_tl_acquire_ready;
  assign gnt_fire = bus.io_tl_grant_valid && bus.io_tl_grant_ready;
  // The counter has already advanced past the tag of the acquire being answered
  assign gnt_ok = bus.io_tl_grant_bits_client_xact_id == xact_cnt - 2'd1 && bus.io_tl_grant_bits_is_builtin_type &&
                  bus.io_tl_grant_bits_g_type == (cur_wr ? G_PUTACK : G_GETDATABEAT);
  assign unused_grant = ^{bus.io_tl_grant_bits_addr_beat, bus.io_tl_grant_bits_manager_xact_id};
`ifdef CORERISCV_AXI4_TL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic stale_vld, stale_hit;
  logic [1:0] stale_tag;
  assign stale_hit = stale_vld && bus.io_tl_grant_bits_client_xact_id == stale_tag;
  // Never reuse the abandoned tag while its grant may still arrive
  assign blocked = stale_vld && stale_tag == xact_cnt;
  assign gnt_take = gnt_fire && state == WAIT_GNT && !stale_hit;
  assign tmo = state == WAIT_GNT && !gnt_take && tcnt == TW'(TIMEOUT_CYCLES - 1);
  assign bus.io_tl_grant_ready = state == WAIT_GNT || stale_vld;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tcnt <= '0;
      stale_vld <= 1'b0;
      stale_tag <= 2'd0;
    end else begin
      tcnt <= state == WAIT_GNT ? tcnt + 1'b1 : '0;
      stale_vld <= tmo || (stale_vld && !(gnt_fire && stale_hit));
      if (tmo) stale_tag <= xact_cnt - 2'd1;
    end
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign blocked = 1'b0;
  assign tmo = 1'b0;
  assign gnt_take = gnt_fire && state == WAIT_GNT;
  assign bus.io_tl_grant_ready = state == WAIT_GNT;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? ACQ : IDLE;
      ACQ: state_nx = acq_fire ? WAIT_GNT : ACQ;
      WAIT_GNT: state_nx = gnt_take || tmo ? (cur_wr ? RESP_B : RESP_R) : WAIT_GNT;
      RESP_B: state_nx = bus.io_axi_b_ready ? IDLE : RESP_B;
      RESP_R: state_nx = bus.io_axi_r_ready ? IDLE : RESP_R;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cur_wr <= 1'b0;
      xact_cnt <= 2'd0;
      resp <= RESP_OKAY;
      rdata <= 64'h0;
    end else begin
      state <= state_nx;
      if (start) cur_wr <= start_wr;
      if (acq_fire) xact_cnt <= xact_cnt + 2'd1;
      if (gnt_take) begin
        resp <= gnt_ok ? RESP_OKAY : RESP_SLVERR;
        rdata <= gnt_ok ? bus.io_tl_grant_bits_data : 64'h0;
      end else if (tmo) begin
        resp <= RESP_DECERR;
        rdata <= 64'h0;
      end
    end
endmodule

// File: doc/coreriscv_axi4_axi2tl_bridge.md
Name: coreriscv_axi4_axi2tl_bridge

Overview:
- AXI4 single-beat slave to TileLink (acquire/grant) master adapter, directly upstream of the PRCI timer/IPI block.
- Converts one AXI read or write at a time into a builtin Get or Put acquire on the PRCI acquire port.
- Returns the PRCI grant to the AXI R or B channel.
- One transaction outstanding; no bursts.

Parameters:
- ID_WIDTH, 4, AXI ID width; echoed on B/R.
- TIMEOUT_CYCLES, 1024, grant-wait limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- reset  in  1  reset; asynchronous, active-high
- io_axi_aw_valid/ready  in/out  1  write-address handshake
- io_axi_aw_id  in  ID_WIDTH  write ID
- io_axi_aw_addr  in  32  write byte address
- io_axi_w_valid/ready  in/out  1  write-data handshake
- io_axi_w_data  in  64  write data
- io_axi_w_strb  in  8  byte strobes
- io_axi_b_valid/ready  out/in  1  write-response handshake
- io_axi_b_id  out  ID_WIDTH  response ID
- io_axi_b_resp  out  2  write response
- io_axi_ar_valid/ready  in/out  1  read-address handshake
- io_axi_ar_id  in  ID_WIDTH  read ID
- io_axi_ar_addr  in  32  read byte address
- io_axi_r_valid/ready  out/in  1  read-data handshake
- io_axi_r_id  out  ID_WIDTH  response ID
- io_axi_r_data  out  64  read data
- io_axi_r_resp  out  2  read response
- io_axi_r_last  out  1  constant 1
- io_tl_acquire_valid/ready  out/in  1  acquire handshake
- io_tl_acquire_bits_addr_block  out  26  addr[31:6]
- io_tl_acquire_bits_client_xact_id  out  2  transaction tag
- io_tl_acquire_bits_addr_beat  out  3  addr[5:3]
- io_tl_acquire_bits_is_builtin_type  out  1  constant 1
- io_tl_acquire_bits_a_type  out  3  3'h0 Get, 3'h2 Put
- io_tl_acquire_bits_union  out  12  see Behaviour
- io_tl_acquire_bits_data  out  64  write data
- io_tl_grant_valid/ready  in/out  1  grant handshake
- io_tl_grant_bits_addr_beat  in  3  ignored
- io_tl_grant_bits_client_xact_id  in  2  tag
- io_tl_grant_bits_manager_xact_id  in  1  ignored
- io_tl_grant_bits_is_builtin_type  in  1  checked
- io_tl_grant_bits_g_type  in  4  checked
- io_tl_grant_bits_data  in  64  read data

Behaviour:
- Reset (async): all valids/readies 0, FSM IDLE, xact counter 0, last_served=WRITE, capture regs 0, resp 2'b00.
- FSM states: IDLE, ACQ, WAIT_GNT, RESP_B, RESP_R.
- IDLE: aw_ready and w_ready are high until each beat is captured; AW and W may arrive in either order or in the same cycle. ar_ready is high only while neither AW nor W has been captured.
- Write eligible when both AW and W are captured; read eligible when AR is captured.
- Both eligible: serve the kind opposite to last_served, then update last_served.
- The chosen request goes to ACQ in the following cycle.
- ACQ: acquire_valid=1 with fields stable until ready.
  - Put: a_type 3'h2, union={3'h0, w_strb, 1'b0}, data=w_data.
  - Get: a_type 3'h0, union={ar_addr[2:0], 3'h3, 5'h0, 1'b0}, data=0.
  - client_xact_id = counter.
- On acquire handshake: counter increments (wraps 3→0), go to WAIT_GNT.
- WAIT_GNT: grant_ready=1. On grant, check tag, builtin and type (Get expects 4'h4, Put expects 4'h3).
  - All match: resp 2'b00, R data latched from grant data.
  - Any mismatch: resp 2'b10 (SLVERR), R data 0.
  - Next state: RESP_B (write) or RESP_R (read).
- RESP_B/RESP_R: valid held until the corresponding ready, then IDLE. Capture flags clear on response handshake.
- Minimum latency: AXI address/data accept to acquire_valid is 1 cycle; grant to B/R valid is 1 cycle.
- Reset mid-transaction: in-flight transaction abandoned; no response issued.
- Only a read landing on a PRCI IPI/timecmp address sees PRCI data; the address map is not checked here.

Optional Feature:
- Macro CORERISCV_AXI4_TL_TIMEOUT_EN.
- With it: a counter runs in WAIT_GNT. On reaching TIMEOUT_CYCLES with no grant, respond 2'b11 (DECERR), R data 0, and record a stale tag.
- While a stale tag is pending, grant_ready stays 1 in every state. A grant carrying the stale tag is discarded and clears the stale flag.
- While the stale flag is set, a new acquire is blocked if its tag would equal the stale tag.
- Without it: wait for the grant indefinitely; no counter logic.

Decomposition:
- Shared package: a_type and g_type constants (GET=3'h0, PUT=3'h2, GETDATABEAT=4'h4, PUTACK=4'h3) and AXI resp codes (OKAY, SLVERR, DECERR).
- One natural sub-module: coreriscv_axi4_axi2tl_capture, the AW/W/AR holding registers with the fair arbiter.

Test Plan:
- Read: AR addr 0x4400_8000, id 5; grant g_type 4, data 0x0000_0000_0000_1234, matching tag → acquire Get, addr_block 0x110_0200, union[11:9]=0; R id 5, data 0x1234, resp 0.
- Write: W first, AW 2 cycles later, addr 0x4400_4000, strb 0xFF → acquire Put, union[8:1]=0xFF; grant g_type 3; B resp 0.
- Simultaneous AR and AW+W with last_served=WRITE → read issued first, write second; xact ids 0 then 1.
- Grant returns a wrong client_xact_id → SLVERR on R, data 0.
- Five sequential transactions → xact id sequence 0,1,2,3,0.
- With timeout enabled, TIMEOUT_CYCLES=16 and no grant → R resp 3 at cycle 16. A late grant with the stale tag is dropped; the next read completes OKAY.
